// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - round-robin arbiter sharing the framebuffer random-access port
module fb_access_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_pix,
    input  logic                           reset_i,
    input  logic [NUM_MASTERS-1:0]         m_sel_i,
    input  logic [NUM_MASTERS-1:0]         m_wr_i,
    input  logic [4*NUM_MASTERS-1:0]       m_mask_i,
    input  logic [24*NUM_MASTERS-1:0]      m_address_i,
    input  logic [16*NUM_MASTERS-1:0]      m_data_i,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_err_o,
    output logic [15:0]                    m_data_o,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           busy_o,
    output logic                           fb_sel_o,
    output logic                           fb_wr_o,
    output logic [3:0]                     fb_mask_o,
    output logic [23:0]                    fb_address_o,
    output logic [15:0]                    fb_data_o,
    input  logic                           fb_ack_i,
    input  logic [15:0]                    fb_data_i,
    output logic                           timeout_err_o
);

    localparam int GW  = $clog2(NUM_MASTERS);
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic                   fb_sel, fb_sel_n;
    logic                   fb_wr, fb_wr_n;
    logic [3:0]             fb_mask, fb_mask_n;
    logic [23:0]            fb_address, fb_address_n;
    logic [15:0]            fb_data, fb_data_n;
    logic [NUM_MASTERS-1:0] m_ack, m_ack_n;
    logic [NUM_MASTERS-1:0] m_err, m_err_n;
    logic [15:0]            m_data, m_data_n;
    logic [GW-1:0]          grant, grant_n;
    logic [GW-1:0]          last, last_n;
    logic [WDW-1:0]         wdog, wdog_n;
    logic                   timeout_err, timeout_err_n;

    // Round-robin search: rotate the request vector so that bit 0 is the
    // master right after the last winner, then take the lowest set bit.
    logic [2*NUM_MASTERS-1:0] sel_dbl;
    logic [NUM_MASTERS-1:0]   sel_rot;
    logic [GW:0]              rr_start;
    logic [GW:0]              offset;
    logic [GW:0]              pick_sum;
    logic                     found;
    logic [GW-1:0]            pick;
    logic                     pick_wr;
    logic [3:0]               pick_mask;
    logic [23:0]              pick_address;
    logic [15:0]              pick_data;
    logic [NUM_MASTERS-1:0]   grant_onehot;

    assign sel_dbl  = {m_sel_i, m_sel_i};
    assign rr_start = {1'b0, last} + (GW+1)'(1);
    assign sel_rot  = sel_dbl[rr_start +: NUM_MASTERS];

    // Find the first requester after the last winner and its rotated offset.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && sel_rot[i]) begin
                found  = 1'b1;
                offset = (GW+1)'(i);
            end
        end
    end

    // Map the rotated offset back to an absolute master index (mod NUM_MASTERS).
    always_comb begin
        pick_sum = rr_start + offset;
        if (pick_sum >= (GW+1)'(NUM_MASTERS)) begin
            pick_sum = pick_sum - (GW+1)'(NUM_MASTERS);
        end
        pick = pick_sum[GW-1:0];
    end

    // Select the winning master's transaction fields.
    always_comb begin
        pick_wr      = 1'b0;
        pick_mask    = 4'h0;
        pick_address = 24'h000000;
        pick_data    = 16'h0000;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick == GW'(i)) begin
                pick_wr      = m_wr_i[i];
                pick_mask    = m_mask_i[4*i +: 4];
                pick_address = m_address_i[24*i +: 24];
                pick_data    = m_data_i[16*i +: 16];
            end
        end
    end

    assign grant_onehot = NUM_MASTERS'(1) << grant;

    // Next-state and next-register logic for the arbitration FSM.
    always_comb begin
        state_n       = state;
        fb_sel_n      = fb_sel;
        fb_wr_n       = fb_wr;
        fb_mask_n     = fb_mask;
        fb_address_n  = fb_address;
        fb_data_n     = fb_data;
        m_ack_n       = '0;
        m_err_n       = '0;
        m_data_n      = m_data;
        grant_n       = grant;
        last_n        = last;
        wdog_n        = wdog;
        timeout_err_n = timeout_err;
        case (state)
            IDLE: begin
                if (found) begin
                    fb_wr_n      = pick_wr;
                    fb_mask_n    = pick_mask;
                    fb_address_n = pick_address;
                    fb_data_n    = pick_data;
                    grant_n      = pick;
                    last_n       = pick;
                    fb_sel_n     = 1'b1;
                    wdog_n       = '0;
                    state_n      = REQ;
                end
            end
            REQ: begin
                if (fb_ack_i) begin
                    fb_sel_n = 1'b0;
                    m_data_n = fb_data_i;
                    m_ack_n  = grant_onehot;
                    state_n  = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (wdog == WD_LIMIT)) begin
                    fb_sel_n      = 1'b0;
                    m_data_n      = 16'h0000;
                    m_ack_n       = grant_onehot;
                    m_err_n       = grant_onehot;
                    timeout_err_n = 1'b1;
                    state_n       = DRAIN;
                end else begin
                    wdog_n = wdog + WDW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            DRAIN: begin
                // The late ack of a timed-out request is swallowed here.
                if (fb_ack_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; last starts at NUM_MASTERS-1 so master 0 wins first.
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            state       <= IDLE;
            fb_sel      <= 1'b0;
            fb_wr       <= 1'b0;
            fb_mask     <= 4'h0;
            fb_address  <= 24'h000000;
            fb_data     <= 16'h0000;
            m_ack       <= '0;
            m_err       <= '0;
            m_data      <= 16'h0000;
            grant       <= '0;
            last        <= GW'(NUM_MASTERS - 1);
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            fb_sel      <= fb_sel_n;
            fb_wr       <= fb_wr_n;
            fb_mask     <= fb_mask_n;
            fb_address  <= fb_address_n;
            fb_data     <= fb_data_n;
            m_ack       <= m_ack_n;
            m_err       <= m_err_n;
            m_data      <= m_data_n;
            grant       <= grant_n;
            last        <= last_n;
            wdog        <= wdog_n;
            timeout_err <= timeout_err_n;
        end
    end

    // The request drops combinationally while its ack is visible so the
    // framebuffer never re-samples a request that is already completing.
    assign fb_sel_o      = fb_sel & ~fb_ack_i;
    assign fb_wr_o       = fb_wr;
    assign fb_mask_o     = fb_mask;
    assign fb_address_o  = fb_address;
    assign fb_data_o     = fb_data;
    assign m_ack_o       = m_ack;
    assign m_err_o       = m_err;
    assign m_data_o      = m_data;
    assign grant_o       = grant;
    assign busy_o        = (state != IDLE);
    assign timeout_err_o = timeout_err;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - directed self-checking bench for fb_access_arbiter
module tb_fb_access_arbiter;

    localparam int N = 2;
    localparam int T = 8;

    logic          clk_pix = 1'b0;
    logic          reset_i = 1'b1;
    logic [N-1:0]  m_sel_i = '0;
    logic [N-1:0]  m_wr_i = '0;
    logic [4*N-1:0]  m_mask_i = '0;
    logic [24*N-1:0] m_address_i = '0;
    logic [16*N-1:0] m_data_i = '0;
    logic [N-1:0]  m_ack_o;
    logic [N-1:0]  m_err_o;
    logic [15:0]   m_data_o;
    logic [0:0]    grant_o;
    logic          busy_o;
    logic          fb_sel_o;
    logic          fb_wr_o;
    logic [3:0]    fb_mask_o;
    logic [23:0]   fb_address_o;
    logic [15:0]   fb_data_o;
    logic          fb_ack_i = 1'b0;
    logic [15:0]   fb_data_i = 16'h0000;
    logic          timeout_err_o;

    int checks = 0;
    int failures = 0;

    bit          model_en = 1'b1;
    int          model_lat = 3;
    logic [15:0] model_rdata = 16'h0000;
    int          model_reqs = 0;
    bit          model_busy = 1'b0;
    int          model_cnt = 0;

    fb_access_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_pix(clk_pix), .reset_i(reset_i),
        .m_sel_i(m_sel_i), .m_wr_i(m_wr_i), .m_mask_i(m_mask_i),
        .m_address_i(m_address_i), .m_data_i(m_data_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_data_o(m_data_o),
        .grant_o(grant_o), .busy_o(busy_o),
        .fb_sel_o(fb_sel_o), .fb_wr_o(fb_wr_o), .fb_mask_o(fb_mask_o),
        .fb_address_o(fb_address_o), .fb_data_o(fb_data_o),
        .fb_ack_i(fb_ack_i), .fb_data_i(fb_data_i),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk_pix = ~clk_pix;

    // Framebuffer model: accepts a request, acks model_lat cycles later.
    always @(posedge clk_pix) begin
        #1;
        if (reset_i) begin
            model_busy = 1'b0;
            fb_ack_i   = 1'b0;
        end else if (model_en) begin
            if (fb_ack_i) begin
                fb_ack_i = 1'b0;
            end else if (model_busy) begin
                model_cnt--;
                if (model_cnt == 0) begin
                    fb_ack_i   = 1'b1;
                    fb_data_i  = model_rdata;
                    model_busy = 1'b0;
                end
            end else if (fb_sel_o) begin
                model_busy = 1'b1;
                model_cnt  = model_lat;
                model_reqs++;
            end
        end
    end

    task automatic tick;
        @(negedge clk_pix);
    endtask

    task automatic set_master(input int k, input logic wr, input logic [3:0] mask,
                              input logic [23:0] addr, input logic [15:0] data);
        m_wr_i[k]             = wr;
        m_mask_i[4*k +: 4]    = mask;
        m_address_i[24*k +: 24] = addr;
        m_data_i[16*k +: 16]  = data;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) tick();
        checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin failures++; $display("FAIL reset_ack_err: got ack=%b err=%b want 00 00", m_ack_o, m_err_o); end
        checks++; if (fb_sel_o !== 1'b0 || fb_wr_o !== 1'b0) begin failures++; $display("FAIL reset_fb_sel_wr: got sel=%b wr=%b want 0 0", fb_sel_o, fb_wr_o); end
        checks++; if (busy_o !== 1'b0 || timeout_err_o !== 1'b0) begin failures++; $display("FAIL reset_busy_terr: got busy=%b terr=%b want 0 0", busy_o, timeout_err_o); end
        checks++; if (m_data_o !== 16'h0 || fb_mask_o !== 4'h0 || fb_address_o !== 24'h0 || fb_data_o !== 16'h0) begin failures++; $display("FAIL reset_data: got mdata=%h mask=%h addr=%h fdata=%h want zeros", m_data_o, fb_mask_o, fb_address_o, fb_data_o); end
        checks++; if (grant_o !== 1'b0) begin failures++; $display("FAIL reset_grant: got %b want 0", grant_o); end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        int acks = 0;
        int rises = 0;
        int cyc = 0;
        int last_ack = -100;
        int reqs0;
        logic prev_sel = 1'b0;
        logic [1:0] pend = 2'b00;
        logic [1:0] exp_ack;
        reqs0 = model_reqs;
        model_lat = 1;
        set_master(0, 1'b1, 4'h3, 24'h000010, 16'h1111);
        set_master(1, 1'b1, 4'hC, 24'h000020, 16'h2222);
        m_sel_i = 2'b11;
        while (cyc < 200 && !(acks == 6 && !busy_o)) begin
            tick();
            cyc++;
            if (fb_sel_o && !prev_sel) begin
                if (rises > 0) begin
                    checks++; if (cyc != last_ack + 2) begin failures++; $display("FAIL cont_gap: rise at cycle %0d want %0d", cyc, last_ack + 2); end
                end
                checks++; if (grant_o !== 1'(rises % 2)) begin failures++; $display("FAIL cont_grant: got %0d want %0d", grant_o, rises % 2); end
                rises++;
            end
            prev_sel = fb_sel_o;
            if (cyc == last_ack + 1) begin
                checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cont_idle: busy=%b want 0", busy_o); end
            end
            if (m_ack_o !== 2'b00) begin
                exp_ack = 2'b01 << (acks % 2);
                checks++; if (m_ack_o !== exp_ack) begin failures++; $display("FAIL cont_ack_order: got %b want %b", m_ack_o, exp_ack); end
                last_ack = cyc;
                acks++;
                m_sel_i = m_sel_i & ~m_ack_o;
                pend = pend | m_ack_o;
                if (acks == 6) begin
                    m_sel_i = 2'b00;
                    pend = 2'b00;
                end
            end else if (pend != 2'b00) begin
                m_sel_i = m_sel_i | pend;
                pend = 2'b00;
            end
        end
        checks++; if (acks != 6) begin failures++; $display("FAIL cont_count: got %0d acks want 6", acks); end
        checks++; if (model_reqs - reqs0 != 6) begin failures++; $display("FAIL cont_reqs: model saw %0d requests want 6", model_reqs - reqs0); end
        tick();
    endtask

    task automatic test_write;
        int cyc = 1;
        int reqs0;
        reqs0 = model_reqs;
        model_lat = 3;
        set_master(1, 1'b1, 4'hF, 24'h000100, 16'hBEEF);
        m_sel_i = 2'b10;
        tick();
        checks++; if (fb_address_o !== 24'h000100 || fb_data_o !== 16'hBEEF || fb_wr_o !== 1'b1 || fb_mask_o !== 4'hF) begin failures++; $display("FAIL wr_fields: got addr=%h data=%h wr=%b mask=%h want 000100 beef 1 f", fb_address_o, fb_data_o, fb_wr_o, fb_mask_o); end
        checks++; if (fb_sel_o !== 1'b1 || grant_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("FAIL wr_grant: got sel=%b grant=%b busy=%b want 1 1 1", fb_sel_o, grant_o, busy_o); end
        while (cyc < 20 && fb_ack_i !== 1'b1) begin
            tick();
            cyc++;
        end
        checks++; if (cyc != 4) begin failures++; $display("FAIL wr_fb_ack_cycle: got cycle %0d want 4", cyc); end
        checks++; if (fb_sel_o !== 1'b0 || m_ack_o !== 2'b00) begin failures++; $display("FAIL wr_blanking: got sel=%b ack=%b want 0 00", fb_sel_o, m_ack_o); end
        tick();
        checks++; if (m_ack_o !== 2'b10 || m_err_o !== 2'b00) begin failures++; $display("FAIL wr_ack: got ack=%b err=%b want 10 00", m_ack_o, m_err_o); end
        m_sel_i = 2'b00;
        tick();
        checks++; if (m_ack_o !== 2'b00 || busy_o !== 1'b0) begin failures++; $display("FAIL wr_after: got ack=%b busy=%b want 00 0", m_ack_o, busy_o); end
        checks++; if (model_reqs - reqs0 != 1) begin failures++; $display("FAIL wr_reqs: model saw %0d requests want 1", model_reqs - reqs0); end
    endtask

    task automatic test_read;
        int cyc = 0;
        model_lat = 2;
        model_rdata = 16'h1234;
        set_master(0, 1'b0, 4'hF, 24'h00ABCD, 16'h0000);
        m_sel_i = 2'b01;
        tick();
        checks++; if (fb_wr_o !== 1'b0 || fb_address_o !== 24'h00ABCD || grant_o !== 1'b0) begin failures++; $display("FAIL rd_fields: got wr=%b addr=%h grant=%b want 0 00abcd 0", fb_wr_o, fb_address_o, grant_o); end
        while (cyc < 20 && m_ack_o === 2'b00) begin
            tick();
            cyc++;
        end
        checks++; if (m_ack_o !== 2'b01 || m_data_o !== 16'h1234 || m_err_o !== 2'b00) begin failures++; $display("FAIL rd_ack: got ack=%b data=%h err=%b want 01 1234 00", m_ack_o, m_data_o, m_err_o); end
        m_sel_i = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_timeout;
        int cyc = 0;
        model_en = 1'b0;
        fb_ack_i = 1'b0;
        set_master(0, 1'b0, 4'hF, 24'h000300, 16'h0000);
        m_sel_i = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 9) begin
                checks++; if (m_ack_o !== 2'b00) begin failures++; $display("FAIL to_early_ack: cycle %0d ack=%b want 00", k, m_ack_o); end
            end else begin
                checks++; if (m_ack_o !== 2'b01 || m_err_o !== 2'b01) begin failures++; $display("FAIL to_ack_err: got ack=%b err=%b want 01 01", m_ack_o, m_err_o); end
                checks++; if (timeout_err_o !== 1'b1 || m_data_o !== 16'h0000) begin failures++; $display("FAIL to_flag_data: got terr=%b data=%h want 1 0000", timeout_err_o, m_data_o); end
            end
        end
        m_sel_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (busy_o !== 1'b1 || fb_sel_o !== 1'b0 || m_ack_o !== 2'b00) begin failures++; $display("FAIL to_drain: got busy=%b sel=%b ack=%b want 1 0 00", busy_o, fb_sel_o, m_ack_o); end
        end
        fb_data_i = 16'hDEAD;
        fb_ack_i = 1'b1;
        tick();
        fb_ack_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || m_ack_o !== 2'b00 || m_data_o !== 16'h0000) begin failures++; $display("FAIL to_late_ack: got busy=%b ack=%b data=%h want 0 00 0000", busy_o, m_ack_o, m_data_o); end
        tick();
        checks++; if (m_ack_o !== 2'b00 || timeout_err_o !== 1'b1) begin failures++; $display("FAIL to_sticky: got ack=%b terr=%b want 00 1", m_ack_o, timeout_err_o); end
        model_en = 1'b1;
        model_lat = 2;
        model_rdata = 16'h5A5A;
        set_master(1, 1'b0, 4'hF, 24'h000400, 16'h0000);
        m_sel_i = 2'b10;
        while (cyc < 20 && m_ack_o === 2'b00) begin
            tick();
            cyc++;
        end
        checks++; if (m_ack_o !== 2'b10 || m_err_o !== 2'b00 || m_data_o !== 16'h5A5A) begin failures++; $display("FAIL to_recover: got ack=%b err=%b data=%h want 10 00 5a5a", m_ack_o, m_err_o, m_data_o); end
        checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL to_sticky2: got terr=%b want 1", timeout_err_o); end
        m_sel_i = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        int seen = 0;
        model_lat = 10;
        set_master(0, 1'b1, 4'h5, 24'h000200, 16'hCAFE);
        m_sel_i = 2'b01;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        checks++; if (m_ack_o !== 2'b00 || busy_o !== 1'b0 || fb_sel_o !== 1'b0 || timeout_err_o !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl: got ack=%b busy=%b sel=%b terr=%b want 00 0 0 0", m_ack_o, busy_o, fb_sel_o, timeout_err_o); end
        checks++; if (fb_address_o !== 24'h0 || fb_data_o !== 16'h0 || fb_mask_o !== 4'h0 || fb_wr_o !== 1'b0 || grant_o !== 1'b0) begin failures++; $display("FAIL rst_mid_regs: got addr=%h data=%h mask=%h wr=%b grant=%b want zeros", fb_address_o, fb_data_o, fb_mask_o, fb_wr_o, grant_o); end
        m_sel_i = 2'b00;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (m_ack_o !== 2'b00) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_mid_no_ack: got %0d ack cycles want 0", seen); end
        model_lat = 1;
        set_master(0, 1'b1, 4'h1, 24'h000500, 16'h0500);
        set_master(1, 1'b1, 4'h2, 24'h000600, 16'h0600);
        m_sel_i = 2'b11;
        tick();
        checks++; if (grant_o !== 1'b0 || fb_sel_o !== 1'b1 || fb_address_o !== 24'h000500) begin failures++; $display("FAIL rst_mid_first: got grant=%b sel=%b addr=%h want 0 1 000500", grant_o, fb_sel_o, fb_address_o); end
        while (cyc < 20 && m_ack_o === 2'b00) begin
            tick();
            cyc++;
        end
        checks++; if (m_ack_o !== 2'b01) begin failures++; $display("FAIL rst_mid_ack0: got %b want 01", m_ack_o); end
        m_sel_i = 2'b10;
        cyc = 0;
        tick();
        while (cyc < 20 && m_ack_o === 2'b00) begin
            tick();
            cyc++;
        end
        checks++; if (m_ack_o !== 2'b10) begin failures++; $display("FAIL rst_mid_ack1: got %b want 10", m_ack_o); end
        m_sel_i = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write();
        test_read();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
